// File: rtl/weight_fetch_ctrl.sv
// Weight BRAM fetch sequencer: streams NUM_F filters x REP passes of WPF weights to the PE array.
// Optional stall_cnt performance counter enabled by defining WFETCH_PERF_CNT_EN.
module weight_fetch_ctrl #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 23184,
    parameter int unsigned WPF_W  = 10,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [WPF_W-1:0]  wpf,
    input  logic [CNT_W-1:0]  num_f,
    input  logic [CNT_W-1:0]  rep,
    output logic [ADDR_W-1:0] bram_read_addr,
    input  logic [DATA_W-1:0] bram_data_out,
    output logic [DATA_W-1:0] w_data,
    output logic              w_valid,
    input  logic              w_ready,
    output logic              w_last,
    output logic [CNT_W-1:0]  w_filt_idx,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef WFETCH_PERF_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int unsigned END_W = ((ADDR_W > WPF_W + CNT_W) ? ADDR_W : WPF_W + CNT_W) + 1;

    typedef enum logic [2:0] {StIdle, StCheck, StRun, StDrain, StDone} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  base_q;
    logic [WPF_W-1:0]   wpf_q;
    logic [CNT_W-1:0]   num_f_q, rep_q;
    logic [WPF_W-1:0]   k_q, k_d;
    logic [CNT_W-1:0]   p_q, p_d, f_q, f_d;
    logic [ADDR_W-1:0]  cur_q, cur_d, fbase_q, fbase_d;
    logic [ADDR_W-1:0]  addr_hold_q;
    logic               inflight_q, infl_last_q;
    logic [CNT_W-1:0]   infl_f_q;
    logic               err_q;

    logic [DATA_W-1:0]  fifo_data_q [2];
    logic               fifo_last_q [2];
    logic [CNT_W-1:0]   fifo_fidx_q [2];
    logic               wr_ptr_q, rd_ptr_q;
    logic [1:0]         count_q;

    logic               start_acc, push, pop, issue, cfg_zero, range_err;
    logic               last_k, last_p, last_f;
    logic [2:0]         credit_used;
    logic [END_W-1:0]   end_addr;

    assign start_acc   = (state_q == StIdle) && start;
    assign w_valid     = (count_q != 2'd0);
    assign pop         = w_valid && w_ready;
    assign push        = inflight_q;
    // A pop this cycle frees a slot, which keeps the stream at one beat per cycle.
    assign credit_used = 3'(inflight_q) + 3'(count_q);
    assign issue       = (state_q == StRun) && (credit_used < 3'd2 + 3'(pop));

    assign end_addr  = END_W'(base_q) + END_W'(wpf_q) * END_W'(num_f_q);
    assign cfg_zero  = (wpf_q == '0) || (num_f_q == '0) || (rep_q == '0);
    assign range_err = (state_q == StCheck) && !cfg_zero && (end_addr > END_W'(DEPTH));

    assign last_k = (k_q == wpf_q - WPF_W'(1));
    assign last_p = (p_q == rep_q - CNT_W'(1));
    assign last_f = (f_q == num_f_q - CNT_W'(1));

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        p_d     = p_q;
        f_d     = f_q;
        cur_d   = cur_q;
        fbase_d = fbase_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StCheck;
            end
            StCheck: begin
                k_d     = '0;
                p_d     = '0;
                f_d     = '0;
                cur_d   = base_q;
                fbase_d = base_q;
                if (cfg_zero || range_err) state_d = StDone;
                else                       state_d = StRun;
            end
            StRun: begin
                if (issue) begin
                    if (!last_k) begin
                        k_d   = k_q + WPF_W'(1);
                        cur_d = cur_q + ADDR_W'(1);
                    end else if (!last_p) begin
                        k_d   = '0;
                        p_d   = p_q + CNT_W'(1);
                        cur_d = fbase_q;
                    end else begin
                        k_d     = '0;
                        p_d     = '0;
                        f_d     = f_q + CNT_W'(1);
                        fbase_d = fbase_q + ADDR_W'(wpf_q);
                        cur_d   = fbase_q + ADDR_W'(wpf_q);
                        if (last_f) state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (!inflight_q && (count_q - 2'(pop)) == 2'd0) state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            base_q      <= '0;
            wpf_q       <= '0;
            num_f_q     <= '0;
            rep_q       <= '0;
            k_q         <= '0;
            p_q         <= '0;
            f_q         <= '0;
            cur_q       <= '0;
            fbase_q     <= '0;
            addr_hold_q <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            infl_f_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            p_q     <= p_d;
            f_q     <= f_d;
            cur_q   <= cur_d;
            fbase_q <= fbase_d;
            if (start_acc) begin
                base_q  <= base_addr;
                wpf_q   <= wpf;
                num_f_q <= num_f;
                rep_q   <= rep;
            end
            if (start_acc)      err_q <= 1'b0;
            else if (range_err) err_q <= 1'b1;
            inflight_q <= issue;
            if (issue) begin
                addr_hold_q <= cur_q;
                infl_last_q <= last_k;
                infl_f_q    <= f_q;
            end
        end
    end

    // Return FIFO; contents are cleared so every output reads 0 while in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
                fifo_fidx_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= bram_data_out;
                fifo_last_q[wr_ptr_q] <= infl_last_q;
                fifo_fidx_q[wr_ptr_q] <= infl_f_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

    assign bram_read_addr = issue ? cur_q : addr_hold_q;
    assign w_data         = fifo_data_q[rd_ptr_q];
    assign w_last         = fifo_last_q[rd_ptr_q];
    assign w_filt_idx     = fifo_fidx_q[rd_ptr_q];
    assign busy           = (state_q == StCheck) || (state_q == StRun) || (state_q == StDrain);
    assign done           = (state_q == StDone);
    assign err            = err_q;

`ifdef WFETCH_PERF_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (start_acc) begin
            stall_cnt_q <= '0;
        end else if (busy && w_valid && !w_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
